// File: rtl/win_pkg.sv
// Shared constants for the Winograd F(2x2,3x3) tile path: pixel width, tile geometry
// and the bit position of each tile element on the 128-bit bus.
package win_pkg;

  localparam int PIX_W  = 8;
  localparam int TILE_N = 16;
  localparam int TILE_W = TILE_N * PIX_W;

  // MSB position of element k; element 0 occupies the top byte of the bus.
  function automatic int tile_slice(input int k);
    return TILE_W - 1 - PIX_W * k;
  endfunction

endpackage

// File: rtl/win_line_buf.sv
// Four-row circular line buffer with one write port and a combinational 4x4 window read.
// The bottom-right window element forwards the write-port data, because the completing
// pixel is only written on the same edge the tile is captured.
module win_line_buf #(
  parameter int IMG_W = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [1:0]                 wr_row,
  input  logic [$clog2(IMG_W)-1:0]   wr_col,
  input  logic [win_pkg::PIX_W-1:0]  wr_data,
  input  logic [1:0]                 rd_row,
  input  logic [$clog2(IMG_W)-1:0]   rd_col,
  output logic [win_pkg::TILE_W-1:0] window
);
  import win_pkg::*;

  localparam int XW = $clog2(IMG_W);

  logic [PIX_W-1:0] mem [4][IMG_W];

  // Pixel storage; contents are intentionally left uninitialised across reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  // Window gather: rows wrap modulo 4, columns are contiguous from rd_col.
  always_comb begin
    window = '0;
    for (int k = 0; k < TILE_N - 1; k++) begin
      window[tile_slice(k) -: PIX_W] = mem[rd_row + 2'(k / 4)][rd_col + XW'(k % 4)];
    end
    window[tile_slice(TILE_N - 1) -: PIX_W] = wr_data;
  end

endmodule

// File: rtl/win_tile_gen.sv
// Raster pixel stream to overlapping 4x4 tiles (stride 2) for the Winograd core.
// A tile is captured on the edge that accepts its bottom-right pixel.
module win_tile_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic [16*PIX_W-1:0]      tile,
  output logic                     tile_valid,
  input  logic                     tile_ready,
  output logic [$clog2(IMG_H)-1:0] tile_row,
  output logic [$clog2(IMG_W)-1:0] tile_col,
  output logic                     tile_last
);
  import win_pkg::*;

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic [XW-1:0]            x_r;
  logic [YW-1:0]            y_r;
  logic [XW-1:0]            c0;
  logic [YW-1:0]            r0;
  logic                     accept;
  logic                     trigger;
  logic                     x_end;
  logic                     y_end;
  logic [TILE_N*PIX_W-1:0]  window;

  assign pix_ready = !rst && (!tile_valid || tile_ready);
  assign accept    = pix_valid && pix_ready;
  assign x_end     = (x_r == XW'(IMG_W - 1));
  assign y_end     = (y_r == YW'(IMG_H - 1));
  assign c0        = x_r - XW'(3);
  assign r0        = y_r - YW'(3);
  // Odd coordinates >= 3 mark the bottom-right corner of a stride-2 tile.
  assign trigger   = accept && y_r[0] && x_r[0] && (y_r >= YW'(3)) && (x_r >= XW'(3));

  win_line_buf #(.IMG_W(IMG_W)) u_line_buf (
    .clk     (clk),
    .we      (accept),
    .wr_row  (y_r[1:0]),
    .wr_col  (x_r),
    .wr_data (pix_in),
    .rd_row  (r0[1:0]),
    .rd_col  (c0),
    .window  (window)
  );

  // Raster counters, tile capture and output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r        <= '0;
      y_r        <= '0;
      tile       <= '0;
      tile_valid <= 1'b0;
      tile_row   <= '0;
      tile_col   <= '0;
      tile_last  <= 1'b0;
    end else begin
      if (accept) begin
        if (x_end) begin
          x_r <= '0;
          y_r <= y_end ? '0 : y_r + YW'(1);
        end else begin
          x_r <= x_r + XW'(1);
        end
      end
      if (trigger) begin
        tile       <= window;
        tile_valid <= 1'b1;
        tile_row   <= {1'b0, r0[YW-1:1]};
        tile_col   <= {1'b0, c0[XW-1:1]};
        tile_last  <= x_end && y_end;
      end else if (tile_ready) begin
        tile_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_win_tile_gen.sv
// Scoreboard bench for win_tile_gen: frames are pushed as expected tile lists at frame
// start, and a negedge monitor compares every tile handshake against them.
module tb_win_tile_gen;
  import win_pkg::*;

  localparam int W = 8;
  localparam int H = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   pix_in;
  logic         pix_valid;
  logic         pix_ready;
  logic [127:0] tile;
  logic         tile_valid;
  logic         tile_ready;
  logic [2:0]   tile_row;
  logic [2:0]   tile_col;
  logic         tile_last;

  typedef struct {
    logic [127:0] t;
    int           r;
    int           c;
    bit           last;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         passed = 0;
  int         tiles_seen = 0;
  int         tr_mode = 0;
  int         gap_pct = 0;
  logic [7:0] img [H][W];

  win_tile_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .tile       (tile),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .tile_row   (tile_row),
    .tile_col   (tile_col),
    .tile_last  (tile_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: tile with top-left (r0,c0) taken straight from the frame image.
  function automatic exp_t ref_tile(input int r0, input int c0);
    exp_t e;
    e.t = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        e.t[127 - 8 * (4 * i + j) -: 8] = img[r0 + i][c0 + j];
    e.r    = r0 / 2;
    e.c    = c0 / 2;
    e.last = (r0 == H - 4) && (c0 == W - 4);
    return e;
  endfunction

  // Downstream ready generator.
  initial begin
    tile_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tr_mode)
        0:       tile_ready = 1'b1;
        1:       tile_ready = 1'($urandom_range(1));
        default: tile_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every accepted tile is popped and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && tile_valid && tile_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_tile", 128'd1, 128'd0);
        end else begin
          e = q.pop_front();
          chk("tile_data", tile, e.t);
          chk("tile_pos", {tile_last, tile_row, tile_col}, {e.last, 3'(e.r), 3'(e.c)});
          tiles_seen++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic send_pixel(input logic [7:0] v);
    bit acc;
    int n;
    if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      pix_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    pix_in    = v;
    pix_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = pix_ready;
      @(posedge clk);
      #1;
      n++;
      if (n > 500) begin
        $display("FAIL pix_accept: got no accept expected accept within 500 cycles");
        $fatal(1);
      end
    end while (!acc);
  endtask

  // mode 0: ramp 8*y+x with directed checks; mode 1: random pixels.
  task automatic send_frame(input int mode, input int hold_at, input int abort_at);
    exp_t e;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = (mode == 0) ? 8'(8 * y + x) : 8'($urandom);
    for (int tr = 0; tr < (H - 2) / 2; tr++)
      for (int tc = 0; tc < (W - 2) / 2; tc++)
        q.push_back(ref_tile(2 * tr, 2 * tc));
    for (int i = 0; i < W * H; i++) begin
      if (i == abort_at) begin
        pix_valid = 1'b0;
        return;
      end
      if (i == hold_at) tr_mode = 2;
      send_pixel(img[i / W][i % W]);
      if (mode == 0) begin
        if (i == 26) chk("pre_first_valid", tile_valid, 128'd0);
        if (i == 27) begin
          chk("first_valid", tile_valid, 128'd1);
          chk("first_tile", tile, 128'h00010203_08090A0B_10111213_18191A1B);
          chk("first_pos", {tile_last, tile_row, tile_col}, 128'd0);
        end
        if (i == 45) begin
          chk("tile45", tile, 128'h12131415_1A1B1C1D_22232425_2A2B2C2D);
          chk("tile45_pos", {tile_last, tile_row, tile_col}, {1'b0, 3'd1, 3'd1});
        end
        if (i == 63) begin
          chk("last_tile", tile, 128'h24252627_2C2D2E2F_34353637_3C3D3E3F);
          chk("last_pos", {tile_last, tile_row, tile_col}, {1'b1, 3'd2, 3'd2});
        end
      end
      if (i == hold_at) begin
        e = ref_tile(0, 0);
        pix_in = img[(i + 1) / W][(i + 1) % W];
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          chk("hold_ready", pix_ready, 128'd0);
          chk("hold_tile", {tile_valid, tile}, {1'b1, e.t});
        end
        tr_mode = 0;
      end
    end
  endtask

  task automatic drain(input int exp_tiles);
    int n;
    pix_valid = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_queue", 128'(q.size()), 128'd0);
    chk("tile_count", 128'(tiles_seen), 128'(exp_tiles));
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_ready"}, pix_ready, 128'd0);
    chk({name, "_outs"}, {tile_valid, tile_last, tile_row, tile_col, tile}, 128'd0);
  endtask

  initial begin
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_in    = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst = 1'b0;

    // Full ramp frame, then backpressure after the first tile.
    tiles_seen = 0;
    send_frame(0, -1, -1);
    drain(9);
    tiles_seen = 0;
    send_frame(0, 27, -1);
    drain(9);

    // Random pix_valid gaps and random tile_ready.
    tr_mode = 1;
    gap_pct = 30;
    tiles_seen = 0;
    send_frame(0, -1, -1);
    drain(9);
    for (int f = 0; f < 2; f++) begin
      tiles_seen = 0;
      send_frame(1, -1, -1);
      drain(9);
    end
    tr_mode = 0;
    gap_pct = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-frame after pixel 30, then a fresh frame.
    send_frame(0, -1, 31);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    @(posedge clk);
    #1;
    check_reset_state("midrst");
    rst = 1'b0;
    tiles_seen = 0;
    send_frame(0, -1, -1);
    drain(9);

    // Two frames back to back.
    tiles_seen = 0;
    send_frame(0, -1, -1);
    send_frame(1, -1, -1);
    drain(18);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
